// File: rtl/mult_arb_pkg.sv
// ============================================================================
// mult_arb_pkg : shared widths and defaults for the multiplier arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mult_arb_pkg;

  localparam int OPW         = 16;  // operand width
  localparam int PW          = 32;  // product width
  localparam int NUM_REQ_DEF = 4;   // default requester count
  localparam int CNT_W       = 16;  // done_cnt width

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

`default_nettype wire

// File: rtl/mult_arbiter_mul.sv
// ============================================================================
// LOBOq2_14bit_1C_v2 : combinational approximate 16x16 multiplier
// Revision           : 1.0
// ============================================================================
`default_nettype none

module LOBOq2_14bit_1C_v2
  import mult_arb_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  logic [13:0]   ah, bh;
  logic [1:0]    al, bl;
  logic [PW-1:0] hh, hl, lh, ll;

  assign ah = a[15:2];
  assign bh = b[15:2];
  assign al = a[1:0];
  assign bl = b[1:0];

  // Upper 14-bit products are exact; only the 2x2 low-part product is
  // approximated (OR of the low bits), so the result is exact whenever either
  // operand has its two low bits clear.
  assign hh = (PW'(ah) * PW'(bh)) << 4;
  assign hl = (PW'(ah) * PW'(bl)) << 2;
  assign lh = (PW'(al) * PW'(bh)) << 2;
  assign ll = ((al != 2'd0) && (bl != 2'd0)) ? PW'(al | bl) : '0;

  assign p = hh + hl + lh + ll;

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ============================================================================
// mult_arbiter : round-robin arbiter sharing one multiplier via a 2-stage
//                elastic pipeline (S1 = operands, S2 = product)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_x,
  input  logic [OPW*NUM_REQ-1:0] req_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [PW-1:0]          res_p,
  output logic [IDW-1:0]         res_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_cnt
);

  // Returns {found, index} of the first valid requester after 'last'.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [IDW-1:0]     last);
    logic           found;
    logic [IDW-1:0] idx;
    int             k;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last) + i) % NUM_REQ;
      if (!found && v[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
    return {found, idx};
  endfunction

  logic [IDW-1:0] last_grant;
  logic           v1, v2;
  logic [OPW-1:0] x1, y1;
  logic [IDW-1:0] id1, id2;
  logic [PW-1:0]  p2;
  logic [PW-1:0]  mul_p;
  logic           en1, en2;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           xfer;

  assign en2 = !v2 || res_ready;
  assign en1 = !v1 || en2;

  assign {pick_found, pick_idx} = rr_pick(req_valid, last_grant);

  always_comb begin
    req_ready = '0;
    if (!rst && en1 && pick_found) req_ready[pick_idx] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      x1         <= '0;
      y1         <= '0;
      id1        <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (en1) begin
      v1 <= xfer;
      if (xfer) begin
        x1         <= req_x[int'(pick_idx)*OPW +: OPW];
        y1         <= req_y[int'(pick_idx)*OPW +: OPW];
        id1        <= pick_idx;
        last_grant <= pick_idx;
      end
    end
  end

  LOBOq2_14bit_1C_v2 u_mul (
    .a (x1),
    .b (y1),
    .p (mul_p)
  );

  // S2 data only moves when S1 actually holds an operand pair, so an idle
  // pipeline keeps the last result visible rather than a stale S1 product.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      p2  <= '0;
      id2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        p2  <= mul_p;
        id2 <= id1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (v2 && res_ready && (done_cnt != CNT_MAX)) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

  assign res_valid = v2;
  assign res_p     = p2;
  assign res_id    = id2;
  assign busy      = v1 | v2;

endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4, number of requesters sharing the multiplier (2..8).
- REQ-002: Parameter IDW, default 2, requester-ID width, SHALL equal clog2(NUM_REQ).
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: req_valid  input  NUM_REQ  per-requester operand-pair valid.
- REQ-006: req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high per cycle.
- REQ-007: req_x  input  16*NUM_REQ  requester i operand X at bits [16i+15:16i].
- REQ-008: req_y  input  16*NUM_REQ  requester i operand Y, same packing.
- REQ-009: res_valid  output  1  result valid.
- REQ-010: res_ready  input  1  downstream accepts result.
- REQ-011: res_p  output  32  product from the shared LOBOq2_14bit_1C_v2 multiplier.
- REQ-012: res_id  output  IDW  index of the requester owning res_p.
- REQ-013: busy  output  1  high while any pipeline stage holds valid data.
- REQ-014: done_cnt  output  16  count of completed result handshakes, saturating at 16'hFFFF.

Function
- REQ-015: Two-stage pipeline: S1 registers x, y, id and v1 into the multiplier inputs; S2 registers the 32-bit product, id and v2 into the result outputs.
- REQ-016: en2 = !v2 | res_ready; en1 = !v1 | en2. Each stage SHALL hold its contents while its enable is low.
- REQ-017: Grant SHALL be round-robin. Search starts at (last_grant+1) mod NUM_REQ and takes the first requester with req_valid set.
- REQ-018: req_ready[g] SHALL be high only for the granted index g, and only when en1=1. It is combinational from req_valid, the priority pointer and en1.
- REQ-019: Transfer occurs when req_valid[g] & req_ready[g]. S1 then loads req_x/req_y slice g, id=g and v1=1. Without a transfer and with en1=1, v1 SHALL load 0.
- REQ-020: last_grant SHALL update to g only on a transfer. A withdrawn req_valid SHALL not move the pointer.
- REQ-021: Latency: a transfer in cycle t yields res_valid=1 in cycle t+2 when res_ready is held high.
- REQ-022: With all requesters valid and res_ready=1, throughput SHALL be one result per cycle, with grant order 0,1,..,NUM_REQ-1,0,...
- REQ-023: While res_valid=1 and res_ready=0, res_p and res_id SHALL remain stable. At most one further transfer is accepted (into S1), then all req_ready go low.
- REQ-024: A simultaneous S2 drain and S1 refill in the same cycle SHALL lose no data.
- REQ-025: A result handshake SHALL increment done_cnt by 1, except at 16'hFFFF, where it holds.
- REQ-026: busy = v1 | v2.

Reset
- REQ-027: While rst=1 at a rising edge: v1=v2=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), done_cnt=0, S1/S2 data registers=0.
- REQ-028: Outputs during reset: res_valid=0, res_p=0, res_id=0, busy=0, req_ready=0.
- REQ-029: A reset asserted mid-operation SHALL discard in-flight operands with no result emitted. The first grant after release SHALL go to the lowest-indexed valid requester.

Structure
- REQ-030: The shared package mult_arb_pkg SHALL hold the operand width (16), product width (32), the NUM_REQ default and the done_cnt width.
- REQ-031: Exactly one sub-module: a single instance of LOBOq2_14bit_1C_v2, driven from the S1 registers, with its output captured by S2.
- REQ-032: The round-robin pick SHALL be a function or block inside mult_arbiter, not a separate module.

Verification
- REQ-033: Reference model: a standalone LOBOq2_14bit_1C_v2 instance. Every res_p SHALL equal the model output for the operands of the requester named by res_id.
- REQ-034: Single request: only req 2 with x=0, y=1234, res_ready=1 -> res_valid in cycle t+2, res_p=0, res_id=2, done_cnt=1.
- REQ-035: All four requesters valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; res_id sequence matches.
- REQ-036: Backpressure: res_ready=0 for 5 cycles with all valid -> exactly 2 transfers, then req_ready=0; res_p stable; after res_ready=1, results resume in order with none lost or duplicated.
- REQ-037: Reset mid-stream: rst pulsed for 1 cycle with v1=v2=1 -> res_valid=0 next cycle, no stale result later, and next grant goes to req 0.
- REQ-038: Saturation: done_cnt preloaded near the limit by 65540 handshakes -> done_cnt=16'hFFFF and remains there.
